// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped 2-bit counter branch predictor
// Predicts from a tagged table of counters, trains on resolved branches, reports mispredicts.
module branch_predictor #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pred_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic              pred_hit,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic              flush,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [1:0]        ctr_q    [DEPTH];
  logic [1:0]        ctr_d    [DEPTH];
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [TAG_W-1:0]  tag_d    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];
  logic [ADDR_W-1:0] target_d [DEPTH];

  logic              mispredict_q, mispredict_d;
  logic [ADDR_W-1:0] redirect_q, redirect_d;
  logic [STAT_W-1:0] branches_q, branches_d;
  logic [STAT_W-1:0] mispreds_q, mispreds_d;

  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic [TAG_W-1:0] pred_tag, upd_tag;
  logic             upd_hit;
  logic             misp_det;

  assign pred_idx = pred_pc[IDX_W-1:0];
  assign pred_tag = pred_pc[ADDR_W-1:IDX_W];
  assign upd_idx  = upd_pc[IDX_W-1:0];
  assign upd_tag  = upd_pc[ADDR_W-1:IDX_W];

  // Lookup reads pre-edge table contents; there is no bypass from a same-cycle update.
  assign pred_hit    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
  assign pred_taken  = pred_hit && ctr_q[pred_idx][1];
  assign pred_target = pred_hit ? target_q[pred_idx] : '0;

  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign misp_det = (upd_pred_taken != upd_taken) ||
                    (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (flush) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
          target_d[upd_idx] = upd_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        ctr_d[upd_idx]    = 2'b10;
        target_d[upd_idx] = upd_target;
      end
    end
  end

  always_comb begin
    mispredict_d = upd_valid && misp_det;
    redirect_d   = redirect_q;
    branches_d   = branches_q;
    mispreds_d   = mispreds_q;
    if (upd_valid) begin
      redirect_d = upd_taken ? upd_target : upd_pc + ADDR_W'(1);
      if (branches_q != {STAT_W{1'b1}}) branches_d = branches_q + STAT_W'(1);
      if (misp_det && (mispreds_q != {STAT_W{1'b1}})) mispreds_d = mispreds_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      branches_q   <= '0;
      mispreds_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      ctr_q        <= ctr_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      branches_q   <= branches_d;
      mispreds_q   <= mispreds_d;
    end
  end

  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_q;
  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispreds_q;

endmodule
